// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin shared bus between NUM_M masters and NUM_S address-decoded slaves
module bus_arbiter_rr #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 2,
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int RD_LAT = 1,
  parameter logic [NUM_S*AW-1:0] S_BASE = {16'h7000, 16'h0000},
  parameter logic [NUM_S*AW-1:0] S_LIMIT = {16'h71ff, 16'h07ff}
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_M-1:0] m_req,
  input  logic [NUM_M-1:0] m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_dout,
  output logic [NUM_M-1:0] m_grant,
  output logic [NUM_M-1:0] m_done,
  output logic m_err,
  output logic [DW-1:0] m_din,
  output logic [NUM_S-1:0] s_sel,
  output logic [AW-1:0] s_addr,
  output logic s_wr,
  output logic [DW-1:0] s_din,
  input  logic [NUM_S*DW-1:0] s_dout
);
  localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS} state_t;
  state_t state, state_n;
  logic [LW-1:0] last, g, win, j;
  logic [CW-1:0] cnt;
  logic miss, fin, found;
  logic [NUM_S-1:0] dec;
  assign fin = (state == ACCESS) && (cnt == '0);
  assign m_done = fin ? m_grant : '0;
  assign m_err = fin & miss;
  // pick the first requester above the last winner, wrapping around
  always_comb begin
    win = '0;
    found = 1'b0;
    j = last;
    for (int i = 0; i < NUM_M; i++) begin
      j = (j == LW'(NUM_M - 1)) ? '0 : j + 1'b1;
      if (!found && m_req[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  // route the granted master onto the slave side; the grant is one-hot so OR-ing is a mux
  always_comb begin
    s_addr = '0;
    s_wr = 1'b0;
    s_din = '0;
    for (int i = 0; i < NUM_M; i++) begin
      s_addr = s_addr | (m_grant[i] ? m_addr[i*AW +: AW] : '0);
      s_wr = s_wr | (m_grant[i] & m_wr[i]);
      s_din = s_din | (m_grant[i] ? m_dout[i*DW +: DW] : '0);
    end
  end
  // address decode, scanned downward so the lowest matching slave wins on overlap
  always_comb begin
    dec = '0;
    for (int k = NUM_S - 1; k >= 0; k--) begin
      if (s_addr >= S_BASE[k*AW +: AW] && s_addr <= S_LIMIT[k*AW +: AW]) begin
        dec = '0;
        dec[k] = 1'b1;
      end
    end
  end
  // return read data of the selected slave, zero when nothing is selected
  always_comb begin
    m_din = '0;
    for (int k = 0; k < NUM_S; k++) m_din = m_din | (s_sel[k] ? s_dout[k*DW +: DW] : '0);
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state: arbitrate, decode for one cycle, then count out the access
  always_comb begin
    state_n = (state == IDLE) ? (|m_req ? GRANT : IDLE) :
              (state == GRANT) ? ACCESS :
              (cnt == '0) ? IDLE : ACCESS;
  end
  // grant, select, latency counter and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_grant <= '0;
      s_sel <= '0;
      miss <= 1'b0;
      cnt <= '0;
      g <= '0;
      last <= LW'(NUM_M - 1);
    end else if (state == IDLE) begin
      if (|m_req) begin
        m_grant <= NUM_M'(1) << win;
        g <= win;
      end
    end else if (state == GRANT) begin
      s_sel <= dec;
      miss <= ~|dec;
      cnt <= s_wr ? '0 : CW'(RD_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      m_grant <= '0;
      s_sel <= '0;
      miss <= 1'b0;
      last <= g;
    end
  end
endmodule
